// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings, FSM states, op decode.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic is_signed(input op_e op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic is_div(input op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign correction of the unsigned magnitude results produced by the iteration.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op_i,
  input  logic             neg_a_i,
  input  logic             neg_b_i,
  input  logic             b_zero_i,
  input  logic [WIDTH-1:0] raw_hi_i,
  input  logic [WIDTH-1:0] raw_lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    prod_neg = -{raw_hi_i, raw_lo_i};
    hi_o     = raw_hi_i;
    lo_o     = raw_lo_i;
    if (is_div(op_i)) begin
      // Remainder follows the dividend; a zero divisor keeps the all-ones quotient.
      if (neg_a_i) hi_o = -raw_hi_i;
      if ((neg_a_i ^ neg_b_i) && !b_zero_i) lo_o = -raw_lo_i;
    end else if (neg_a_i ^ neg_b_i) begin
      hi_o = prod_neg[2*WIDTH-1:WIDTH];
      lo_o = prod_neg[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers, one result bit per cycle.
// Define MULDIV_EARLY_TERM_EN to end multiplies once the remaining multiplier is zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // Handshake: start_i is taken only in IDLE with abort_i low; busy_o then stays high through
  // RUN and FIX, and done_o pulses for one cycle with hi_o/lo_o already holding the result.

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0]   mpl_q, mpl_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  op_e                op_in;
  logic               a_neg, b_neg, b_zero, div_ge, run_last;
  logic [WIDTH-1:0]   a_abs, b_abs, rem_new, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     rem_sh;

  assign op_in   = op_e'(op_i);
  assign a_neg   = is_signed(op_in) && a_i[WIDTH-1];
  assign b_neg   = is_signed(op_in) && b_i[WIDTH-1];
  assign a_abs   = a_neg ? -a_i : a_i;
  assign b_abs   = b_neg ? -b_i : b_i;
  assign b_zero  = (opd_q[WIDTH-1:0] == '0);

  // Multiply: accumulate a left-shifting multiplicand while the multiplier shifts right.
  assign mul_acc = acc_q + (mpl_q[0] ? opd_q : '0);

  // Divide: acc holds {remainder, dividend->quotient}; restoring trial subtract per step.
  assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge  = (rem_sh >= {1'b0, opd_q[WIDTH-1:0]});
  assign rem_new = div_ge ? WIDTH'(rem_sh - {1'b0, opd_q[WIDTH-1:0]}) : rem_sh[WIDTH-1:0];

`ifdef MULDIV_EARLY_TERM_EN
  assign run_last = (cnt_q == CNT_W'(1)) || (!is_div(op_q) && ((mpl_q >> 1) == '0));
`else
  assign run_last = (cnt_q == CNT_W'(1));
`endif

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op_i     (op_q),
    .neg_a_i  (neg_a_q),
    .neg_b_i  (neg_b_q),
    .b_zero_i (b_zero),
    .raw_hi_i (acc_q[2*WIDTH-1:WIDTH]),
    .raw_lo_i (acc_q[WIDTH-1:0]),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    mpl_d   = mpl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i && !abort_i) begin
          state_d = RUN;
          op_d    = op_in;
          neg_a_d = a_neg;
          neg_b_d = b_neg;
          cnt_d   = CNT_W'(WIDTH);
          if (is_div(op_in)) begin
            acc_d = {{WIDTH{1'b0}}, a_abs};
            opd_d = {{WIDTH{1'b0}}, b_abs};
            mpl_d = '0;
          end else begin
            acc_d = '0;
            opd_d = {{WIDTH{1'b0}}, a_abs};
            mpl_d = b_abs;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (is_div(op_q)) begin
            acc_d = {rem_new, acc_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_acc;
            opd_d = opd_q << 1;
            mpl_d = mpl_q >> 1;
          end
          if (run_last) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort_i) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= MULT;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      mpl_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      mpl_q   <= mpl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32) with an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk_i, rst_i, start_i, abort_i, hi_we_i, lo_we_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i, wdata_i;
  logic         busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  int           tests = 0;
  int           fails = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0] cur_hi, cur_lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .abort_i (abort_i),
    .hi_we_i (hi_we_i),
    .lo_we_i (lo_we_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    case (op)
      MULT:  return sa * sb;
      MULTU: return {32'b0, a} * {32'b0, b};
      DIV: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_lat(input op_e op, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_TERM_EN
    logic [W-1:0] babs;
    int n;
    if (op == MULT || op == MULTU) begin
      babs = (op == MULT && b[W-1]) ? -b : b;
      n = 1;
      for (int i = 0; i < W; i++) if (babs[i]) n = i + 1;
      return n + 1;
    end
`endif
    return (op == MULTU) ? W + 1 : (op == MULT) ? W + 1 : W + 1;
  endfunction

  // scoreboard: every done_o pulse must match the oldest expected result
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending op");
      end else begin
        check("result", {hi_o, lo_o}, exp_q.pop_front());
        check("busy_at_done", 64'(busy_o), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic start_op(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_q.push_back(model(op, a, b));
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat, input int elapsed, input bit poke);
    int n;
    n = elapsed;
    while (!done_o && n < 200) begin
      if (poke && n == 4 && busy_o) begin
        start_i = 1'b1;
        op_i    = MULTU;
        a_i     = 32'h0BAD_0BAD;
        b_i     = 32'h0000_0002;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk_i); #1;
      n++;
    end
    start_i = 1'b0;
    check(name, 64'(n), 64'(lat));
    {cur_hi, cur_lo} = {hi_o, lo_o};
    @(posedge clk_i); #1;
    check("done_pulse", 64'(done_o), 64'd0);
  endtask

  task automatic run_op(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    start_op(op, a, b);
    wait_done("latency", exp_lat(op, b), 0, poke);
  endtask

  initial begin
    int seen;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    op_i = 2'b00; a_i = '0; b_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_state", {30'b0, busy_o, done_o, hi_o, lo_o}, 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // pin the model with hand-computed values
    check("model_mult",  model(MULT, 32'hFFFF_FFFD, 32'd7),        64'hFFFF_FFFF_FFFF_FFEB);
    check("model_divu",  model(DIVU, 32'd100, 32'd7),              64'h0000_0002_0000_000E);
    check("model_div",   model(DIV, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
    check("model_div0",  model(DIV, 32'd5, 32'd0),                 64'h0000_0005_FFFF_FFFF);
    check("model_ovf",   model(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    // main function: directed vectors
    run_op(MULT,  32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_lit", {cur_hi, cur_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(DIVU,  32'd100, 32'd7, 1'b0);
    check("divu_lit", {cur_hi, cur_lo}, 64'h0000_0002_0000_000E);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(DIV,   32'd5, 32'd0, 1'b0);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(DIV,   32'hFFFF_FFF9, 32'd0, 1'b0);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(DIV,   32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(DIVU,  32'hFFFF_FFFF, 32'd16, 1'b0);
    run_op(MULTU, 32'h0000_1234, 32'd3, 1'b0);
    check("multu3_lit", {cur_hi, cur_lo}, 64'h0000_0000_0000_369C);
    run_op(MULT,  32'd12345, 32'd0, 1'b0);

    // start while busy is ignored: result and latency unaffected
    run_op(DIV, 32'hFFFF_FF00, 32'd9, 1'b1);

    // abort mid-run: back to idle, no done, HI/LO untouched
    start_op(MULTU, 32'd5, 32'd5);
    void'(exp_q.pop_back());
    repeat (9) begin @(posedge clk_i); #1; end
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_hilo", {hi_o, lo_o}, {cur_hi, cur_lo});
    seen = 0;
    repeat (40) begin @(posedge clk_i); #1; if (done_o) seen++; end
    check("abort_no_done", 64'(seen), 64'd0);

    // abort together with start in idle: abort wins
    start_i = 1'b1; abort_i = 1'b1; op_i = MULTU; a_i = 32'd2; b_i = 32'd2;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    check("abort_start_idle", 64'(busy_o), 64'd0);

    // direct HI/LO writes in idle
    hi_we_i = 1'b1; wdata_i = 32'hA5A5_A5A5;
    @(posedge clk_i); #1;
    hi_we_i = 1'b0;
    check("mthi_idle", 64'(hi_o), 64'hA5A5_A5A5);
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h1234_5678;
    @(posedge clk_i); #1;
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    check("mthilo_idle", {hi_o, lo_o}, 64'h1234_5678_1234_5678);
    cur_hi = 32'h1234_5678; cur_lo = 32'h1234_5678;

    // writes while busy are ignored
    start_op(DIVU, 32'd100, 32'd7);
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    check("mthilo_busy", {hi_o, lo_o}, {cur_hi, cur_lo});
    wait_done("latency_wr_busy", exp_lat(DIVU, 32'd7), 1, 1'b0);

    // write and start in the same idle cycle: write lands, op later overwrites
    hi_we_i = 1'b1; wdata_i = 32'h1111_1111;
    start_op(MULTU, 32'd3, 32'd4);
    hi_we_i = 1'b0;
    check("mthi_with_start", 64'(hi_o), 64'h1111_1111);
    wait_done("latency_wr_start", exp_lat(MULTU, 32'd4), 0, 1'b0);
    check("mult_overwrites", {cur_hi, cur_lo}, 64'd12);

    // asynchronous reset mid-run
    start_op(MULT, 32'hFFFF_0000, 32'h0000_7FFF);
    repeat (10) begin @(posedge clk_i); #1; end
    #2;
    rst_i = 1'b1;
    #1;
    check("async_reset", {30'b0, busy_o, done_o, hi_o, lo_o}, 64'd0);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    run_op(DIV, 32'hFFFF_FF9C, 32'd7, 1'b0);

    repeat (3) begin @(posedge clk_i); #1; end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers for the pipelined CPU; sits beside the EX-stage ALU.
- Width-parametrised and multi-cycle (one bit per cycle). Handles signed and unsigned MULT and DIV, plus direct HI/LO writes.
- The pipeline stalls on busy_o and reads hi_o/lo_o directly.

Parameters:
- WIDTH, 32, operand and result width; must be >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  begin operation; accepted only when idle
- op_i  in  2  operation: MULT, MULTU, DIV, DIVU (package encodings)
- a_i  in  WIDTH  multiplicand / dividend
- b_i  in  WIDTH  multiplier / divisor
- abort_i  in  1  cancel in-flight operation (pipeline flush)
- hi_we_i  in  1  write wdata_i into HI (MTHI)
- lo_we_i  in  1  write wdata_i into LO (MTLO)
- wdata_i  in  WIDTH  HI/LO direct-write data
- busy_o  out  1  operation in flight
- done_o  out  1  one-cycle pulse: HI/LO just updated by an operation
- hi_o  out  WIDTH  HI: product upper half / remainder
- lo_o  out  WIDTH  LO: product lower half / quotient

Behaviour:
- Reset (async, any time, including mid-operation):
  - state IDLE; busy_o=0, done_o=0, hi_o=0, lo_o=0.
  - Internal operand and counter registers cleared.
- States: IDLE, RUN, FIX.
  - IDLE→RUN: when start_i=1 and abort_i=0. On that edge latch op, |a|, |b| (absolute value for signed ops) and sign flags; counter=WIDTH.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; counter decrements. When counter reaches 1, next state is FIX.
  - FIX→IDLE: one edge. Applies sign correction, writes hi_o/lo_o, and registers done_o=1 for exactly the following cycle.
- Latency and handshake:
  - busy_o=1 throughout RUN and FIX.
  - Start edge to done_o is WIDTH+1 edges: 33 for WIDTH=32, 9 for WIDTH=8.
  - hi_o/lo_o are valid in the same cycle done_o is high.
- Sign rules:
  - Product negated (2·WIDTH-bit) if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: lo_o = all ones, hi_o = original a_i. Same cycle count as a normal divide.
- Signed overflow (MIN / -1): lo_o=MIN, hi_o=0. This is the natural result of the algorithm; no special path.
- Boundary and simultaneous events:
  - start_i while busy_o=1: ignored.
  - abort_i while busy_o=1: next edge returns to IDLE, hi_o/lo_o unchanged, no done_o.
  - abort_i with start_i in IDLE: abort wins; no start.
  - hi_we_i/lo_we_i in IDLE: written on that edge, both allowed together. If start_i is in the same cycle, the write occurs and the operation later overwrites HI/LO.
  - hi_we_i/lo_we_i while busy: ignored.
  - op_i/a_i/b_i are sampled only on the accepting edge.

Optional Feature:
- MULDIV_EARLY_TERM_EN defined:
  - Multiply ops leave RUN for FIX on the edge where the remaining shifted multiplier becomes zero.
  - RUN length = max(1, index of highest set bit of |b| + 1).
  - Latency = RUN length + 1 (e.g. |b|=3 gives 3 edges; b=0 gives 2 edges).
  - Divide is unaffected.
- Undefined: every operation takes fixed WIDTH+1 edges.

Decomposition:
- muldiv_pkg:
  - op encodings: MULT=2'b00, MULTU=2'b01, DIV=2'b10, DIVU=2'b11
  - state enum: IDLE, RUN, FIX
  - helper is_signed(op), is_div(op)
- One sub-module: muldiv_sign_fix. Combinational; takes raw unsigned hi/lo plus sign flags and op, and returns the corrected hi/lo. Instantiated once and used in FIX.

Test Plan:
- MULT, WIDTH=32, a=-3 (0xFFFFFFFD), b=7, start at edge 0 → done_o high after edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy_o low the same cycle.
- DIVU a=100, b=7 → lo=14, hi=2. DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5 after 33 edges. DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0.
- Abort and busy interaction:
  - Start MULTU 5×5, abort_i at edge 10 → busy_o=0 after edge 11, no done_o, HI/LO keep prior values.
  - start_i asserted at edge 5 while busy → ignored.
- hi_we_i=1, wdata=0xA5A5A5A5 in IDLE → hi_o=0xA5A5A5A5 next cycle. Same write while busy → no change.
- rst_i asserted asynchronously mid-RUN → busy_o, done_o, hi_o, lo_o = 0 immediately. With MULDIV_EARLY_TERM_EN: MULTU b=3 → done after 3 edges, lo=3·a.
